// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_pkg
// Shared raster timing definitions for the video pipeline: the default
// 800x600@60 timing set (40 MHz pixel clock), the counter type and a helper
// that derives a line/frame total from its four segments. Drawing stages
// reuse the DEF_H_ACTIVE/DEF_V_ACTIVE screen bounds from here.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_timing_gen_pkg;

  // Counters are 11 bits, so each axis total must not exceed 2048.
  localparam int CNT_W = 11;

  typedef logic [CNT_W-1:0] count_t;
  // One bit wider than a count so that segment ends equal to 2048 still fit.
  typedef logic [CNT_W:0]   count_ext_t;

  // Registered per-axis flags that travel with the counter value.
  typedef struct packed {
    logic blnk;
    logic sync;
  } axis_flags_t;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Raster timing stream from the timing generator to the first drawing stage.
//   hcount_out  : horizontal position, 0..H_TOTAL-1
//   vcount_out  : vertical position, 0..V_TOTAL-1
//   hsync_out   : horizontal sync (at H_SYNC_POL level when active)
//   hblnk_out   : horizontal blanking
//   vsync_out   : vertical sync (at V_SYNC_POL level when active)
//   vblnk_out   : vertical blanking
//   frame_start : one-cycle pulse at position (0,0)
// master = timing generator, slave = downstream consumer.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  count_t hcount_out;
  count_t vcount_out;
  logic   hsync_out;
  logic   hblnk_out;
  logic   vsync_out;
  logic   vblnk_out;
  logic   frame_start;

  modport master (
    output hcount_out, vcount_out, hsync_out, hblnk_out,
           vsync_out, vblnk_out, frame_start
  );

  modport slave (
    input  hcount_out, vcount_out, hsync_out, hblnk_out,
           vsync_out, vblnk_out, frame_start
  );

endinterface

// File: rtl/vga_timing_gen_axis_ctr.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_axis_ctr
// One raster axis: a position counter with terminal-count wrap plus the
// blanking and sync flags for that position. Used once for the horizontal
// axis (step_i tied high) and once for the vertical axis (step_i = the
// horizontal wrap).
// Ports:
//   pclk    in  pixel clock
//   rst     in  synchronous reset, active-high
//   step_i  in  advance the counter this cycle
//   count_o out registered position
//   blnk_o  out registered blanking flag for count_o
//   sync_o  out registered sync flag for count_o (at POL level when active)
//   wrap_o  out combinational: counter goes from TOTAL-1 to 0 at the next edge
// -----------------------------------------------------------------------------
module vga_timing_gen_axis_ctr
  import vga_timing_gen_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b1
) (
  input  logic   pclk,
  input  logic   rst,
  input  logic   step_i,
  output count_t count_o,
  output logic   blnk_o,
  output logic   sync_o,
  output logic   wrap_o
);

  localparam int         TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam count_t     LAST       = count_t'(TOTAL - 1);
  localparam count_ext_t ACTIVE_END = count_ext_t'(ACTIVE);
  localparam count_ext_t SYNC_START = count_ext_t'(ACTIVE + FP);
  localparam count_ext_t SYNC_END   = count_ext_t'(ACTIVE + FP + SYNC);

  count_t      count_q, count_d;
  axis_flags_t flags_q, flags_d;
  logic        wrap;
  count_ext_t  count_ext;

  // Next position: hold, increment, or wrap to 0 after the terminal count.
  always_comb begin
    wrap    = step_i && (count_q == LAST);
    count_d = count_q;
    if (step_i) begin
      count_d = wrap ? '0 : count_q + count_t'(1);
    end
  end

  // Flags are decoded from the next position so that, once registered, they
  // describe exactly the count presented in the same cycle.
  always_comb begin
    count_ext    = {1'b0, count_d};
    flags_d.blnk = (count_ext >= ACTIVE_END);
    flags_d.sync = ((count_ext >= SYNC_START) && (count_ext < SYNC_END)) ? POL : ~POL;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      count_q <= '0;
      flags_q <= '{blnk: 1'b0, sync: ~POL};
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign count_o = count_q;
  assign blnk_o  = flags_q.blnk;
  assign sync_o  = flags_q.sync;
  assign wrap_o  = wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Head of the video pipeline: produces the raster timing stream (pixel
// counters, sync pulses, blanking flags, frame_start). Every output is
// registered in the same stage, so all fields are coherent each cycle.
// Ports:
//   pclk   in  pixel clock (only clock)
//   rst    in  synchronous reset, active-high
//   vga_o  master modport of vga_timing_gen_if carrying the timing stream
// Each axis total (ACTIVE+FP+SYNC+BP) must be at most 2048.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit H_SYNC_POL = 1'b1,
  parameter bit V_SYNC_POL = 1'b1
) (
  input  logic             pclk,
  input  logic             rst,
  vga_timing_gen_if.master vga_o
);

  count_t h_count, v_count;
  logic   h_blnk, h_sync, h_wrap;
  logic   v_blnk, v_sync, v_wrap;
  logic   frame_start_q, frame_start_d;

  vga_timing_gen_axis_ctr #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_SYNC_POL)
  ) u_h_ctr (
    .pclk    (pclk),
    .rst     (rst),
    .step_i  (1'b1),
    .count_o (h_count),
    .blnk_o  (h_blnk),
    .sync_o  (h_sync),
    .wrap_o  (h_wrap)
  );

  // The vertical axis only advances on the horizontal wrap, so its flags can
  // only change in the cycle where hcount returns to 0.
  vga_timing_gen_axis_ctr #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_SYNC_POL)
  ) u_v_ctr (
    .pclk    (pclk),
    .rst     (rst),
    .step_i  (h_wrap),
    .count_o (v_count),
    .blnk_o  (v_blnk),
    .sync_o  (v_sync),
    .wrap_o  (v_wrap)
  );

  // Next position is (0,0) exactly when both axes wrap together. The (0,0)
  // held in reset is not a wrap, so no pulse for the frame entered via reset.
  assign frame_start_d = h_wrap & v_wrap;

  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_o.hcount_out  = h_count;
  assign vga_o.vcount_out  = v_count;
  assign vga_o.hsync_out   = h_sync;
  assign vga_o.hblnk_out   = h_blnk;
  assign vga_o.vsync_out   = v_sync;
  assign vga_o.vblnk_out   = v_blnk;
  assign vga_o.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Scoreboard bench for vga_timing_gen using a reduced timing set so that
// several full frames fit in a short run. The driver issues one rst value per
// edge and pushes the expected output for that edge, derived from the number
// of edges since reset release (position = t mod frame, split into h and v
// with division). A monitor on the falling edge pops and compares all fields,
// and also measures the distance between successive frame_start pulses.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  localparam int HA = 16, HF = 3, HS = 5, HB = 4;
  localparam int VA = 10, VF = 2, VS = 3, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 28
  localparam int VT = VA + VF + VS + VB;   // 17
  localparam int FRAME = HT * VT;          // 476
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  vga_timing_gen_if vga_if ();

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .H_SYNC_POL (HPOL), .V_SYNC_POL (VPOL)
  ) dut (
    .pclk  (pclk),
    .rst   (rst),
    .vga_o (vga_if)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit r;
    int h;
    int v;
    bit hs;
    bit hb;
    bit vs;
    bit vb;
    bit fs;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   t        = 0;   // edges since reset release

  function automatic exp_t model(input bit r, input int tt);
    exp_t e;
    int   p;
    e.r = r;
    if (r) begin
      e.h = 0; e.v = 0; e.hb = 0; e.vb = 0; e.fs = 0;
      e.hs = !HPOL; e.vs = !VPOL;
    end else begin
      p    = tt % FRAME;
      e.h  = p % HT;
      e.v  = p / HT;
      e.hb = (e.h >= HA);
      e.vb = (e.v >= VA);
      e.hs = (e.h >= HA + HF && e.h < HA + HF + HS) ? HPOL : !HPOL;
      e.vs = (e.v >= VA + VF && e.v < VA + VF + VS) ? VPOL : !VPOL;
      e.fs = (p == 0);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // One edge with the given reset value; expectation queued after the edge.
  task automatic step(input bit r);
    rst = r;
    @(posedge pclk);
    #1;
    if (r) t = 0;
    else   t = t + 1;
    sb_q.push_back(model(r, t));
  endtask

  // Advance until the model's current position is (h,v), bounded by a frame.
  task automatic run_to(input int h, input int v);
    int k = 0;
    while (!(((t % FRAME) % HT) == h && ((t % FRAME) / HT) == v) && k < FRAME) begin
      step(1'b0);
      k++;
    end
    check("run_to_reach", (k < FRAME) ? 1 : 0, 1);
  endtask

  // Monitor: compare every queued expectation half a cycle after its edge.
  exp_t e_mon;
  int   cyc     = 0;
  int   last_fs = -1;

  always @(negedge pclk) begin
    if (sb_q.size() > 0) begin
      e_mon = sb_q.pop_front();
      cyc++;
      check("hcount",      32'(vga_if.hcount_out), e_mon.h);
      check("vcount",      32'(vga_if.vcount_out), e_mon.v);
      check("hsync",       32'(vga_if.hsync_out),  32'(e_mon.hs));
      check("hblnk",       32'(vga_if.hblnk_out),  32'(e_mon.hb));
      check("vsync",       32'(vga_if.vsync_out),  32'(e_mon.vs));
      check("vblnk",       32'(vga_if.vblnk_out),  32'(e_mon.vb));
      check("frame_start", 32'(vga_if.frame_start), 32'(e_mon.fs));
      if (e_mon.r) begin
        last_fs = -1;
      end else if (vga_if.frame_start === 1'b1) begin
        if (last_fs >= 0) check("frame_period", cyc - last_fs, FRAME);
        last_fs = cyc;
      end
    end
  end

  initial begin
    rst = 1'b1;
    // Reset from arbitrary power-up state, then first edge after release.
    repeat (5) step(1'b1);
    step(1'b0);
    // Line wrap mid-frame, then the simultaneous h/v wrap.
    run_to(HT - 1, 5);
    step(1'b0);
    run_to(HT - 1, VT - 1);
    step(1'b0);
    // Several uninterrupted frames for sync windows and frame period.
    repeat (3 * FRAME) step(1'b0);
    // Mid-frame reset with syncs inactive.
    run_to(10, 5);
    step(1'b1);
    repeat (5) step(1'b0);
    // Reset during the hsync pulse.
    run_to(HA + HF + 2, 3);
    step(1'b1);
    step(1'b1);
    repeat (5) step(1'b0);
    // Reset during the vsync pulse.
    run_to(5, VA + VF + 1);
    step(1'b1);
    repeat (3) step(1'b0);
    // Random run lengths and reset bursts.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 2 * FRAME)) step(1'b0);
      repeat ($urandom_range(1, 3)) step(1'b1);
    end
    repeat (2 * FRAME + 5) step(1'b0);
    @(negedge pclk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
